// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline front end: the canonical NOP,
// the fetch FSM state encoding and the default reset fetch address.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Per cycle: flush > hold > load > bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DAT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_write,
    input  logic                  i_load,
    input  logic [DAT_WIDTH-1:0]  i_ins,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [ADDR_WIDTH-1:0] i_pc4,
    output logic [DAT_WIDTH-1:0]  o_ins,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc4,
    output logic                  o_valid
);

    localparam logic [DAT_WIDTH-1:0] NOP_W = DAT_WIDTH'(NOP_INSTR);

    logic [DAT_WIDTH-1:0]  r_ins;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc4;
    logic                  r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ins   <= NOP_W;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_ins   <= NOP_W;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_write) begin
            if (i_load) begin
                r_ins   <= i_ins;
                r_pc    <= i_pc;
                r_pc4   <= i_pc4;
                r_valid <= 1'b1;
            end else begin
                // Nothing delivered this cycle: Decode sees a bubble.
                r_ins   <= NOP_W;
                r_pc    <= '0;
                r_pc4   <= '0;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_ins   = r_ins;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PC_F, keeps a single instruction-memory read in flight and
// feeds the IF/ID register, absorbing stalls, redirects and variable latency.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DAT_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PC_Write,
    input  logic                  IF_ID_Write,
    input  logic                  PCSrc_E,
    input  logic [ADDR_WIDTH-1:0] PC_Target_E,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DAT_WIDTH-1:0]  imem_rdata,
    input  logic                  imem_rvalid,
    output logic [DAT_WIDTH-1:0]  Ins_D,
    output logic [ADDR_WIDTH-1:0] PC_D,
    output logic [ADDR_WIDTH-1:0] PC_4D,
    output logic                  Valid_D
);

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DAT_WIDTH-1:0]  r_hold_buf;

    logic                  w_go;
    logic                  w_deliver;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [DAT_WIDTH-1:0]  w_ins;

    assign w_go       = PC_Write & IF_ID_Write;
    assign w_target   = {PC_Target_E[ADDR_WIDTH-1:2], 2'b00};
    assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);

    // A redirect always beats delivery, even when the word is on the bus.
    assign w_deliver  = !PCSrc_E && w_go &&
                        (((r_state == WAIT) && imem_rvalid) || (r_state == HOLD));
    assign w_ins      = (r_state == HOLD) ? r_hold_buf : imem_rdata;

    // Gated by rst_n so no request escapes while reset is held.
    assign imem_req   = rst_n && (r_state == IDLE) && !PCSrc_E;
    assign imem_addr  = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (PCSrc_E) r_pc    <= w_target;
                    else         r_state <= WAIT;
                end
                WAIT: begin
                    if (PCSrc_E) begin
                        r_pc    <= w_target;
                        r_state <= imem_rvalid ? IDLE : DROP;
                    end else if (imem_rvalid) begin
                        if (w_go) begin
                            r_pc    <= w_pc_plus4;
                            r_state <= IDLE;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (PCSrc_E) begin
                        r_pc    <= w_target;
                        r_state <= IDLE;
                    end else if (w_go) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= IDLE;
                    end
                end
                DROP: begin
                    // The stale response still has to drain before a new request.
                    if (PCSrc_E)     r_pc    <= w_target;
                    if (imem_rvalid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == WAIT) && imem_rvalid && !PCSrc_E && !w_go)
            r_hold_buf <= imem_rdata;
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DAT_WIDTH  (DAT_WIDTH)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (PCSrc_E),
        .i_write (IF_ID_Write),
        .i_load  (w_deliver),
        .i_ins   (w_ins),
        .i_pc    (r_pc),
        .i_pc4   (w_pc_plus4),
        .o_ins   (Ins_D),
        .o_pc    (PC_D),
        .o_pc4   (PC_4D),
        .o_valid (Valid_D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected IF/ID
// contents, a monitor pops and compares on each newly presented instruction.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        PC_Write, IF_ID_Write, PCSrc_E;
    logic [31:0] PC_Target_E;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] Ins_D, PC_D, PC_4D;
    logic        Valid_D;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata  = '0;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_ins, w_pc, w_pc4;
    logic        w_valid;

    int n_run  = 0;
    int n_fail = 0;
    int lat    = 1;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;
    exp_t sb[$];

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC_Write    (PC_Write),
        .IF_ID_Write (IF_ID_Write),
        .PCSrc_E     (PCSrc_E),
        .PC_Target_E (PC_Target_E),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .Ins_D       (Ins_D),
        .PC_D        (PC_D),
        .PC_4D       (PC_4D),
        .Valid_D     (Valid_D)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC_Write    (PC_Write),
        .IF_ID_Write (IF_ID_Write),
        .PCSrc_E     (PCSrc_E),
        .PC_Target_E (PC_Target_E),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_rdata  (w_rdata),
        .imem_rvalid (w_rvalid),
        .Ins_D       (w_ins),
        .PC_D        (w_pc),
        .PC_4D       (w_pc4),
        .Valid_D     (w_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory for the main DUT: data = 0x1234_0000 ^ addr, latency lat cycles.
    int          m_cnt;
    logic [31:0] m_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt       <= 0;
            m_addr      <= '0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            if (m_cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= 32'h1234_0000 ^ m_addr;
                m_cnt       <= 0;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
            if (imem_req) begin
                m_addr <= imem_addr;
                if (lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= 32'h1234_0000 ^ imem_addr;
                end else begin
                    m_cnt <= lat - 1;
                end
            end
        end
    end

    // Memory for the wrap instance: latency 1, data = addr.
    always @(posedge clk) begin
        w_rvalid <= w_req;
        w_rdata  <= w_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.ins = ins;
        e.pc  = pc;
        e.pc4 = pc4;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d entries still pending, expected 0", sb.size());
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ins"},   Ins_D,           NOP);
        chk({tag, "_pc"},    PC_D,            32'h0);
        chk({tag, "_pc4"},   PC_4D,           32'h0);
        chk({tag, "_valid"}, 32'(Valid_D),    32'h0);
        chk({tag, "_req"},   32'(imem_req),   32'h0);
    endtask

    // Monitor: compare each newly presented instruction against the scoreboard.
    initial begin
        logic        prev_v;
        logic [31:0] prev_pc;
        exp_t        e;
        prev_v  = 1'b0;
        prev_pc = '0;
        forever begin
            @(posedge clk);
            #2;
            if (Valid_D === 1'b1 && (!prev_v || PC_D !== prev_pc)) begin
                if (sb.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected: got Ins_D 0x%08h PC_D 0x%08h, expected no instruction",
                             Ins_D, PC_D);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ins", Ins_D, e.ins);
                    chk("sb_pc",  PC_D,  e.pc);
                    chk("sb_pc4", PC_4D, e.pc4);
                end
            end
            prev_v  = Valid_D;
            prev_pc = PC_D;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        PCSrc_E     = 1'b0;
        PC_Target_E = '0;
        lat         = 1;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");

        // Sequential fetch, L=1
        push(32'h1234_0000, 32'h0000_0000, 32'h0000_0004);
        push(32'h1234_0004, 32'h0000_0004, 32'h0000_0008);
        push(32'h1234_0008, 32'h0000_0008, 32'h0000_000C);
        rst_n = 1'b1;
        #1;
        chk("wrap_req0",  32'(w_req), 32'h1);
        chk("wrap_addr0", w_addr,     32'hFFFF_FFFC);
        for (int k = 0; k < 3; k++) begin
            chk("seq_req_on", 32'(imem_req), 32'h1);
            chk("seq_addr",   imem_addr,     32'(4 * k));
            if (k == 1) begin
                chk("wrap_valid", 32'(w_valid), 32'h1);
                chk("wrap_ins",   w_ins,        32'hFFFF_FFFC);
                chk("wrap_pc",    w_pc,         32'hFFFF_FFFC);
                chk("wrap_pc4",   w_pc4,        32'h0000_0000);
                chk("wrap_addr1", w_addr,       32'h0000_0000);
            end
            @(negedge clk);
            chk("seq_req_off", 32'(imem_req), 32'h0);
            @(negedge clk);
        end

        // Stall while the response arrives
        chk("stall_req_pre",  32'(imem_req), 32'h1);
        chk("stall_addr_pre", imem_addr,     32'h0000_000C);
        push(32'h1234_000C, 32'h0000_000C, 32'h0000_0010);
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 32'h0);
            chk("stall_pc",  PC_D,          32'h0000_0008);
            chk("stall_ins", Ins_D,         32'h1234_0008);
        end
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        @(negedge clk);
        chk("stall_rel_req",  32'(imem_req), 32'h1);
        chk("stall_rel_addr", imem_addr,     32'h0000_0010);
        chk("stall_rel_pc",   PC_D,          32'h0000_000C);

        // Redirect while waiting, L=3
        lat = 3;
        @(negedge clk);
        chk("redir_wait_req", 32'(imem_req), 32'h0);
        PCSrc_E     = 1'b1;
        PC_Target_E = 32'h0000_0101;
        @(negedge clk);
        PCSrc_E     = 1'b0;
        PC_Target_E = '0;
        chk("redir_flush_ins",   Ins_D,          NOP);
        chk("redir_flush_valid", 32'(Valid_D),   32'h0);
        chk("redir_drop_req",    32'(imem_req),  32'h0);
        push(32'h1234_0100, 32'h0000_0100, 32'h0000_0104);
        @(negedge clk);
        chk("redir_drop_req2", 32'(imem_req), 32'h0);
        @(negedge clk);
        chk("redir_new_req",  32'(imem_req), 32'h1);
        chk("redir_new_addr", imem_addr,     32'h0000_0100);
        chk("redir_no_stale", Ins_D,         NOP);
        chk("redir_no_valid", 32'(Valid_D),  32'h0);
        drain();

        // Redirect together with rvalid and stall, L=1
        lat = 1;
        chk("combo_req_pre",  32'(imem_req), 32'h1);
        chk("combo_addr_pre", imem_addr,     32'h0000_0104);
        @(negedge clk);
        PCSrc_E     = 1'b1;
        PC_Target_E = 32'h0000_0200;
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        @(negedge clk);
        PCSrc_E     = 1'b0;
        PC_Target_E = '0;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        #1;
        chk("combo_ins",   Ins_D,          NOP);
        chk("combo_valid", 32'(Valid_D),   32'h0);
        chk("combo_pc",    PC_D,           32'h0);
        chk("combo_req",   32'(imem_req),  32'h1);
        chk("combo_addr",  imem_addr,      32'h0000_0200);
        push(32'h1234_0200, 32'h0000_0200, 32'h0000_0204);
        drain();

        // Reset asserted while waiting, IF/ID held valid beforehand
        lat = 3;
        IF_ID_Write = 1'b0;
        chk("rstw_req_pre",  32'(imem_req), 32'h1);
        chk("rstw_addr_pre", imem_addr,     32'h0000_0204);
        @(negedge clk);
        chk("rstw_wait_req",   32'(imem_req), 32'h0);
        chk("rstw_held_valid", 32'(Valid_D),  32'h1);
        chk("rstw_held_pc",    PC_D,          32'h0000_0200);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rstw");
        IF_ID_Write = 1'b1;
        repeat (2) @(negedge clk);
        push(32'h1234_0000, 32'h0000_0000, 32'h0000_0004);
        rst_n = 1'b1;
        #1;
        chk("rstw_refetch_req",  32'(imem_req), 32'h1);
        chk("rstw_refetch_addr", imem_addr,     32'h0000_0000);
        drain();

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
